// File: rtl/counter_pkg.sv
// Shared constants for the counter family: the limit-behaviour mode encodings.
package counter_pkg;
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;
endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick per DIV enabled cycles; degenerates to tick = en when DIV == 1.
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    generate
        if (DIV == 1) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, sync_clr};
            assign tick      = en;
        end else begin : g_div
            localparam int CW = $clog2(DIV);
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] presc_reg;
            logic [CW-1:0] presc_next;

            // The phase freezes while en is low so a paused count resumes mid-period.
            always_comb begin
                presc_next = presc_reg;
                if (sync_clr) begin
                    presc_next = '0;
                end else if (en) begin
                    presc_next = (presc_reg == LAST) ? '0 : presc_reg + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    presc_reg <= '0;
                end else begin
                    presc_reg <= presc_next;
                end
            end

            assign tick = en && (presc_reg == LAST);
        end
    endgenerate
endmodule

// File: rtl/flex_counter.sv
// Up/down counter with clear, saturating load, prescaled stepping and wrap or saturate limits.
module flex_counter
    import counter_pkg::*;
#(
    parameter int W      = 4,
    parameter int INIT_V = 0,
    parameter int MAX_V  = 2**W - 1,
    parameter int MODE   = 0,
    parameter int DIV    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_v,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         wrap
);
    generate
        if (!(INIT_V >= 0 && INIT_V <= MAX_V && longint'(MAX_V) <= ((longint'(1) << W) - 1)
              && DIV >= 1 && (MODE == MODE_WRAP || MODE == MODE_SAT))) begin : g_bad_params
            $error("flex_counter: illegal parameter combination");
        end
    endgenerate

    localparam logic [W-1:0] MAX_C  = W'(MAX_V);
    localparam logic [W-1:0] INIT_C = W'(INIT_V);

    logic         tick;
    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic         wrap_reg;
    logic         wrap_next;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (clr | load),
        .tick     (tick)
    );

    // Increments only happen below MAX_C and decrements only above zero, so no W-bit overflow.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (clr) begin
            count_next = INIT_C;
        end else if (load) begin
            count_next = (load_v > MAX_C) ? MAX_C : load_v;
        end else if (tick) begin
            if (dir) begin
                if (count_reg != MAX_C) begin
                    count_next = count_reg + W'(1);
                end else if (MODE == MODE_WRAP) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (count_reg != '0) begin
                    count_next = count_reg - W'(1);
                end else if (MODE == MODE_WRAP) begin
                    count_next = MAX_C;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= INIT_C;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;
    assign tc    = (dir && (count_reg == MAX_C)) || (!dir && (count_reg == '0));
endmodule
